// File: rtl/powlib_hs_pkg.sv
// Shared definitions for the 4-phase handshake arbiter: FSM encoding and
// a constant-foldable ceil(log2) helper used to size index fields.
package powlib_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping around. Returns one-hot grant, its index and an any flag.
module powlib_rr_arbiter
  import powlib_hs_pkg::*;
#(
  parameter  int N  = 4,
  localparam int GW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [GW-1:0] gnt_id,
  output logic          any
);

  logic [GW:0]   sum;
  logic [GW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so a single subtraction is enough for the wrap
      sum = {1'b0, ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N)) begin
        sum = sum - (GW+1)'(N);
      end
      idx = sum[GW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/powlib_hs_arbiter.sv
// Source-side controller sharing one 4-phase req/ack crossing among N
// requesters: round-robin grant, word capture into a holding register, REQ/REL sequencing.
module powlib_hs_arbiter
  import powlib_hs_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 16,
  parameter  int TO = 0,
  localparam int GW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_vld,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_rdy,
  output logic            xreq,
  output logic [W-1:0]    xdata,
  input  logic            xack,
  output logic            busy,
  output logic [GW-1:0]   grant_id,
  output logic            err
);

  localparam int CW = (TO > 1) ? clog2(TO) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TO > 0) ? TO - 1 : 0);

  // Handshake: a requester's word is consumed in the cycle in_vld[i] & in_rdy[i];
  // in_rdy is a one-cycle registered pulse, so requesters hold in_vld/in_data until then.

  hs_state_e     state;
  hs_state_e     state_nxt;
  logic [GW-1:0] ptr;
  logic [GW-1:0] ptr_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [N-1:0]  in_rdy_nxt;
  logic [W-1:0]  xdata_nxt;
  logic [GW-1:0] grant_id_nxt;
  logic          err_nxt;

  logic [N-1:0]  arb_gnt;
  logic [GW-1:0] arb_id;
  logic          arb_any;
  logic          grant;
  logic [W-1:0]  words [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = in_data[i*W +: W];
  end

  powlib_rr_arbiter #(.N(N)) u_rr (
    .req    (in_vld),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // A stale ack from the previous transfer blocks any new grant
  assign grant = (state == IDLE) && arb_any && !xack;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    in_rdy_nxt   = '0;
    xdata_nxt    = xdata;
    grant_id_nxt = grant_id;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt    = REQ;
          in_rdy_nxt   = arb_gnt;
          xdata_nxt    = words[arb_id];
          grant_id_nxt = arb_id;
          ptr_nxt      = (arb_id == GW'(N-1)) ? '0 : arb_id + GW'(1);
          cnt_nxt      = '0;
        end
      end
      REQ: begin
        if (xack) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else if ((TO != 0) && (cnt == TO_LAST)) begin
          state_nxt = REL;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      REL: begin
        if (!xack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      in_rdy   <= '0;
      xreq     <= 1'b0;
      xdata    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      in_rdy   <= in_rdy_nxt;
      xreq     <= (state_nxt == REQ);
      xdata    <= xdata_nxt;
      busy     <= (state_nxt != IDLE);
      grant_id <= grant_id_nxt;
      err      <= err_nxt;
    end
  end

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_rdy));
  a_rdy_xreq:   assert property (@(posedge clk) disable iff (!rst) (in_rdy != '0) |-> xreq);
  a_busy_state: assert property (@(posedge clk) disable iff (!rst) busy == (state != IDLE));
  a_xreq_state: assert property (@(posedge clk) disable iff (!rst) xreq == (state == REQ));

endmodule

// File: tb/tb_powlib_hs_arbiter.sv
// Directed bench for powlib_hs_arbiter: auto/forced ack model, in_rdy monitor
// with scoreboard queues, hand-computed cycle timelines.
module tb_powlib_hs_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_vld;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_rdy;
  logic           xreq;
  logic [W-1:0]   xdata;
  logic           xack = 1'b0;
  logic           busy;
  logic [GW-1:0]  grant_id;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_mode = 1;  // 0 auto, 1 forced low, 2 forced high
  int hi_cnt  = 0;
  int lo_cnt  = 0;
  int rdy1_seen = 0;
  int cnt;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   got_data_q[$];
  logic [N-1:0]   got_rdy_q[$];
  int             got_cyc_q[$];

  powlib_hs_arbiter #(.N(N), .W(W), .TO(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .xreq     (xreq),
    .xdata    (xdata),
    .xack     (xack),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ack model: rise on the 3rd low phase with xreq high, fall 2 low phases after xreq drops
  always @(negedge clk) begin
    if (ack_mode == 0) begin
      if (xreq && !xack) begin
        hi_cnt++;
        if (hi_cnt == 3) begin
          xack = 1'b1;
          hi_cnt = 0;
        end
      end else begin
        hi_cnt = 0;
      end
      if (!xreq && xack) begin
        lo_cnt++;
        if (lo_cnt == 2) begin
          xack = 1'b0;
          lo_cnt = 0;
        end
      end else begin
        lo_cnt = 0;
      end
    end else begin
      xack = (ack_mode == 2);
      hi_cnt = 0;
      lo_cnt = 0;
    end
  end

  // in_rdy monitor
  always @(negedge clk) begin
    cyc++;
    if (in_rdy != '0) begin
      got_rdy_q.push_back(in_rdy);
      got_data_q.push_back(xdata);
      got_cyc_q.push_back(cyc);
      if (in_rdy[1]) rdy1_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    in_data[i*W +: W] = w;
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max && busy; k++) step();
    check("idle_wait", 32'(busy), 32'h0);
  endtask

  task automatic clear_q();
    got_rdy_q.delete();
    got_data_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    in_vld = '0;
    in_data = '0;
    ack_mode = 0;
    step();
    step();
    check("rst_xreq",     32'(xreq),     32'h0);
    check("rst_in_rdy",   32'(in_rdy),   32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_xdata",    32'(xdata),    32'h0);
    check("rst_err",      32'(err),      32'h0);
    rst = 1'b1;
    step();

    // single requester, exact handshake timeline
    set_word(1, 16'hA5A5);
    in_vld = 4'b0010;
    step();
    check("t1_rdy",      32'(in_rdy),   32'h2);
    check("t1_xreq",     32'(xreq),     32'h1);
    check("t1_xdata",    32'(xdata),    32'hA5A5);
    check("t1_grant_id", 32'(grant_id), 32'h1);
    check("t1_busy",     32'(busy),     32'h1);
    in_vld = '0;
    step();
    check("t1_rdy_pulse", 32'(in_rdy), 32'h0);
    check("t1_xreq_c1",   32'(xreq),   32'h1);
    step();
    check("t1_xreq_c2",   32'(xreq),   32'h1);
    step();
    check("t1_xreq_fall", 32'(xreq),   32'h0);
    check("t1_busy_rel",  32'(busy),   32'h1);
    check("t1_xdata_hold", 32'(xdata), 32'hA5A5);
    step();
    check("t1_busy_c4",   32'(busy),   32'h1);
    step();
    check("t1_busy_clr",  32'(busy),   32'h0);

    // all four pending: rotation 0,1,2,3,0 with 6-cycle spacing under this ack model
    do_reset();
    clear_q();
    for (int i = 0; i < N; i++) set_word(i, W'(i));
    in_vld = 4'b1111;
    for (int k = 0; k < 60 && got_rdy_q.size() < 5; k++) step();
    in_vld = '0;
    wait_idle(20);
    check("t2_count", 32'(got_rdy_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) exp_q.push_back(W'(k % N));
    for (int k = 0; k < 5 && k < got_rdy_q.size(); k++) begin
      check("t2_rdy",  32'(got_rdy_q[k]),  32'(1 << (k % N)));
      check("t2_data", 32'(got_data_q[k]), 32'(exp_q.pop_front()));
      if (k > 0) check("t2_spacing", 32'(got_cyc_q[k] - got_cyc_q[k-1]), 32'd6);
    end

    // timeout: ack held low, xreq high for exactly TO cycles, err sticky
    ack_mode = 1;
    step();
    set_word(2, 16'hBEEF);
    in_vld = 4'b0100;
    step();
    check("t3_rdy", 32'(in_rdy), 32'h4);
    in_vld = '0;
    cnt = 0;
    for (int k = 0; k < 30 && xreq; k++) begin
      cnt++;
      step();
    end
    check("t3_xreq_len", 32'(cnt), 32'd8);
    check("t3_err", 32'(err), 32'h1);
    wait_idle(10);
    check("t3_err_idle", 32'(err), 32'h1);
    ack_mode = 0;
    set_word(3, 16'hC33C);
    in_vld = 4'b1000;
    step();
    check("t3_next_rdy",   32'(in_rdy),   32'h8);
    check("t3_next_id",    32'(grant_id), 32'h3);
    check("t3_next_xdata", 32'(xdata),    32'hC33C);
    in_vld = '0;
    wait_idle(30);
    check("t3_err_sticky", 32'(err), 32'h1);

    // ack stuck high in IDLE blocks grants until it drops
    ack_mode = 2;
    step();
    set_word(0, 16'h1234);
    in_vld = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_no_rdy",  32'(in_rdy), 32'h0);
      check("t4_no_xreq", 32'(xreq),   32'h0);
    end
    ack_mode = 1;
    step();
    check("t4_rdy_same_cycle", 32'(in_rdy), 32'h0);
    step();
    check("t4_rdy_after", 32'(in_rdy), 32'h1);
    check("t4_xdata",     32'(xdata),  32'h1234);
    in_vld = '0;
    ack_mode = 0;
    wait_idle(30);

    // asynchronous reset in REQ, then pointer back at requester 0
    ack_mode = 1;
    set_word(1, 16'h5A5A);
    in_vld = 4'b0010;
    step();
    check("t5_rdy_pre", 32'(in_rdy), 32'h2);
    in_vld = '0;
    rst = 1'b0;
    #1;
    check("t5_async_xreq",   32'(xreq),   32'h0);
    check("t5_async_busy",   32'(busy),   32'h0);
    check("t5_async_in_rdy", 32'(in_rdy), 32'h0);
    check("t5_async_err",    32'(err),    32'h0);
    step();
    rst = 1'b1;
    ack_mode = 0;
    set_word(0, 16'h0A0A);
    set_word(3, 16'h3B3B);
    in_vld = 4'b1001;
    step();
    check("t5_rdy0",   32'(in_rdy),   32'h1);
    check("t5_id0",    32'(grant_id), 32'h0);
    check("t5_xdata0", 32'(xdata),    32'h0A0A);
    in_vld = 4'b1000;
    wait_idle(30);
    step();
    check("t5_rdy3",   32'(in_rdy),   32'h8);
    check("t5_xdata3", 32'(xdata),    32'h3B3B);
    in_vld = '0;
    wait_idle(30);

    // in_vld[1] pulsed while busy must never be granted
    clear_q();
    rdy1_seen = 0;
    set_word(0, 16'h7777);
    in_vld = 4'b0001;
    step();
    check("t6_rdy0", 32'(in_rdy), 32'h1);
    in_vld = 4'b0010;
    step();
    in_vld = '0;
    wait_idle(30);
    for (int k = 0; k < 4; k++) step();
    check("t6_rdy1_never", 32'(rdy1_seen), 32'h0);
    check("t6_count", 32'(got_rdy_q.size()), 32'd1);

    // lone requester 0 wins again with ptr at 1 (wrap-around)
    in_vld = 4'b0001;
    step();
    check("t7_rdy0_again", 32'(in_rdy),   32'h1);
    check("t7_id0_again",  32'(grant_id), 32'h0);
    in_vld = '0;
    wait_idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
